rs_issue_ctrl: RTL
==================

RS_ISSUE_CTRL -- requirements
Module: rs_issue_ctrl

Interface
REQ-001 SHALL have parameters: RS_ENT_NUM, default 2, number of RS entries; RS_ENT_SEL, default 1, entry index width; TAG_WIDTH, default 6, source tag width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_flush  in  1  pipeline flush; discard all entries.
- i_alloc_vld_1 / i_alloc_vld_2  in  1  allocation request, ports 1/2.
- i_alloc_sel_1 / i_alloc_sel_2  in  RS_ENT_SEL  entry written by ports 1/2.
- i_src1_tag_1, i_src2_tag_1, i_src1_tag_2, i_src2_tag_2  in  TAG_WIDTH  source tags per port.
- i_src1_rdy_1, i_src2_rdy_1, i_src1_rdy_2, i_src2_rdy_2  in  1  source already available at dispatch.
- i_cdb_vld  in  1  result broadcast valid.
- i_cdb_tag  in  TAG_WIDTH  tag of broadcast result.
- o_busy_vec  out  RS_ENT_NUM  occupied entries, fed to the RS allocation logic.
- o_issue_vld  out  1  an entry is offered to the execution unit.
- o_issue_sel  out  RS_ENT_SEL  index of the offered entry.
- i_issue_rdy  in  1  execution unit accepts the offer.

Function
REQ-003 SHALL keep per-entry registered state: busy, src1_rdy, src2_rdy, src1_tag, src2_tag.
REQ-004 When i_alloc_vld_n is high, SHALL, at the next edge, set busy[i_alloc_sel_n] and load its tags and ready bits from port n.
REQ-005 At allocation, a source SHALL load as ready if its i_srcX_rdy_n is high, or if i_cdb_vld is high and i_cdb_tag equals its tag (same-cycle bypass).
REQ-006 For each busy entry with a non-ready source whose tag equals i_cdb_tag while i_cdb_vld is high, SHALL set that source's ready bit at the next edge.
REQ-007 An entry SHALL be eligible when busy, src1_rdy and src2_rdy are all set in registered state; an allocation or wakeup SHALL make an entry eligible no earlier than the following cycle.
REQ-008 o_issue_vld SHALL be high when any entry is eligible or a lock is held.
REQ-009 Without a lock, o_issue_sel SHALL be the lowest-index eligible entry.
REQ-010 If o_issue_vld is high and i_issue_rdy is low, SHALL set a lock holding o_issue_sel; while the lock is held, o_issue_sel SHALL stay constant even if a lower-index entry becomes eligible.
REQ-011 On o_issue_vld and i_issue_rdy both high, SHALL clear busy and both ready bits of o_issue_sel and release the lock at the next edge; at most one issue per cycle.
REQ-012 o_busy_vec SHALL equal the registered busy bits, with no combinational path from any input.
REQ-013 o_issue_vld and o_issue_sel SHALL be combinational from registered state only, with no path from i_issue_rdy.
REQ-014 i_flush SHALL clear all busy, ready and lock state at the next edge and SHALL take priority over allocation, wakeup and issue in the same cycle.
REQ-015 The following are illegal and SHALL each be flagged by a simulation assertion: allocating an entry that is busy; both alloc ports with the same index while both are valid.

Reset
REQ-016 While i_rst is high, all busy, ready and lock state SHALL be 0, so o_busy_vec=0, o_issue_vld=0 and o_issue_sel=0; tag registers need no reset.
REQ-017 i_rst asserted mid-handshake SHALL immediately drop o_issue_vld, with no issue recorded.

Structure
REQ-018 Shared constants (DP_NUM_WIDTH, TAG_WIDTH default, RS sizing) SHALL come from the shared constants header; no local copies.
REQ-019 Lowest-index eligible selection SHALL reuse the existing req_arbiter sub-module (REQ_NUM=RS_ENT_NUM, ACK_SEL=RS_ENT_SEL); per-entry state SHALL live in this module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Alloc port1 to entry 0, both sources ready -> o_busy_vec=2'b01 next cycle, o_issue_vld=1 and o_issue_sel=0 in that cycle; with i_issue_rdy=1, o_busy_vec=0 one cycle later.
- Alloc entry 1 with src1 tag 5 not ready; drive cdb_vld, tag 5 one cycle later -> o_issue_vld rises the cycle after the broadcast, o_issue_sel=1.
- Alloc with src2 tag 9 not ready while cdb_vld=1, tag=9 in the same cycle -> entry eligible next cycle (bypass).
- Entry 1 offered with i_issue_rdy=0, then entry 0 becomes eligible -> o_issue_sel stays 1 until accepted, then 0 is offered.
- Both entries busy and offered, i_flush=1 with i_issue_rdy=1 -> o_busy_vec=0, o_issue_vld=0 next cycle, no entry retained.
- i_rst pulsed during a pending offer -> o_issue_vld=0 immediately; all outputs 0 after release.

Source files
------------

// File: rtl/rs_issue_ctrl_pkg.sv
// Shared constants for the reservation-station issue control.
// Sizing defaults used by the RS allocation and issue logic.
package rs_issue_ctrl_pkg;

    localparam int DP_NUM_WIDTH   = 2;
    localparam int TAG_WIDTH_DEF  = 6;
    localparam int RS_ENT_NUM_DEF = 2;
    localparam int RS_ENT_SEL_DEF = 1;

endpackage

// File: rtl/req_arbiter.sv
// Fixed-priority arbiter: grants the lowest-index active request.
// Combinational; o_ack_sel is 0 when nothing is requested.
module req_arbiter #(
    parameter int REQ_NUM = 2,
    parameter int ACK_SEL = 1
) (
    input  logic [REQ_NUM-1:0] i_req,
    output logic               o_ack_vld,
    output logic [ACK_SEL-1:0] o_ack_sel
);

    always_comb begin
        o_ack_vld = |i_req;
        o_ack_sel = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (i_req[i]) o_ack_sel = ACK_SEL'(i);
        end
    end

endmodule

// File: rtl/rs_issue_ctrl.sv
// Reservation-station entry tracking, CDB wakeup and issue offer
// with a hold lock so a stalled offer never changes its index.
module rs_issue_ctrl
    import rs_issue_ctrl_pkg::*;
#(
    parameter int RS_ENT_NUM = RS_ENT_NUM_DEF,
    parameter int RS_ENT_SEL = RS_ENT_SEL_DEF,
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_alloc_vld_1,
    input  logic                  i_alloc_vld_2,
    input  logic [RS_ENT_SEL-1:0] i_alloc_sel_1,
    input  logic [RS_ENT_SEL-1:0] i_alloc_sel_2,
    input  logic [TAG_WIDTH-1:0]  i_src1_tag_1,
    input  logic [TAG_WIDTH-1:0]  i_src2_tag_1,
    input  logic [TAG_WIDTH-1:0]  i_src1_tag_2,
    input  logic [TAG_WIDTH-1:0]  i_src2_tag_2,
    input  logic                  i_src1_rdy_1,
    input  logic                  i_src2_rdy_1,
    input  logic                  i_src1_rdy_2,
    input  logic                  i_src2_rdy_2,
    input  logic                  i_cdb_vld,
    input  logic [TAG_WIDTH-1:0]  i_cdb_tag,
    output logic [RS_ENT_NUM-1:0] o_busy_vec,
    output logic                  o_issue_vld,
    output logic [RS_ENT_SEL-1:0] o_issue_sel,
    input  logic                  i_issue_rdy
);

    logic [RS_ENT_NUM-1:0] busy_q, busy_d;
    logic [RS_ENT_NUM-1:0] rdy1_q, rdy1_d;
    logic [RS_ENT_NUM-1:0] rdy2_q, rdy2_d;
    logic [TAG_WIDTH-1:0]  tag1_q [RS_ENT_NUM];
    logic [TAG_WIDTH-1:0]  tag2_q [RS_ENT_NUM];
    logic                  lock_q, lock_d;
    logic [RS_ENT_SEL-1:0] lsel_q, lsel_d;

    logic [RS_ENT_NUM-1:0] elig;
    logic                  arb_vld;
    logic [RS_ENT_SEL-1:0] arb_sel;

    assign elig = busy_q & rdy1_q & rdy2_q;

    req_arbiter #(
        .REQ_NUM (RS_ENT_NUM),
        .ACK_SEL (RS_ENT_SEL)
    ) u_arb (
        .i_req     (elig),
        .o_ack_vld (arb_vld),
        .o_ack_sel (arb_sel)
    );

    assign o_busy_vec  = busy_q;
    assign o_issue_vld = lock_q | arb_vld;
    assign o_issue_sel = lock_q ? lsel_q : arb_sel;

    always_comb begin
        busy_d = busy_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        lock_d = lock_q;
        lsel_d = lsel_q;
        for (int i = 0; i < RS_ENT_NUM; i++) begin
            if (i_cdb_vld && busy_q[i]) begin
                if (tag1_q[i] == i_cdb_tag) rdy1_d[i] = 1'b1;
                if (tag2_q[i] == i_cdb_tag) rdy2_d[i] = 1'b1;
            end
        end
        // Allocation sees the same-cycle broadcast so no wakeup is lost
        if (i_alloc_vld_1) begin
            busy_d[i_alloc_sel_1] = 1'b1;
            rdy1_d[i_alloc_sel_1] = i_src1_rdy_1 |
                (i_cdb_vld && i_cdb_tag == i_src1_tag_1);
            rdy2_d[i_alloc_sel_1] = i_src2_rdy_1 |
                (i_cdb_vld && i_cdb_tag == i_src2_tag_1);
        end
        if (i_alloc_vld_2) begin
            busy_d[i_alloc_sel_2] = 1'b1;
            rdy1_d[i_alloc_sel_2] = i_src1_rdy_2 |
                (i_cdb_vld && i_cdb_tag == i_src1_tag_2);
            rdy2_d[i_alloc_sel_2] = i_src2_rdy_2 |
                (i_cdb_vld && i_cdb_tag == i_src2_tag_2);
        end
        if (o_issue_vld) begin
            if (i_issue_rdy) begin
                busy_d[o_issue_sel] = 1'b0;
                rdy1_d[o_issue_sel] = 1'b0;
                rdy2_d[o_issue_sel] = 1'b0;
                lock_d              = 1'b0;
            end else begin
                lock_d = 1'b1;
                lsel_d = o_issue_sel;
            end
        end
        if (i_flush) begin
            busy_d = '0;
            rdy1_d = '0;
            rdy2_d = '0;
            lock_d = 1'b0;
            lsel_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            lock_q <= 1'b0;
            lsel_q <= '0;
        end else begin
            busy_q <= busy_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
            lock_q <= lock_d;
            lsel_q <= lsel_d;
        end
    end

    // Tags are only meaningful while busy, so they carry no reset
    always_ff @(posedge i_clk) begin
        if (i_alloc_vld_1) begin
            tag1_q[i_alloc_sel_1] <= i_src1_tag_1;
            tag2_q[i_alloc_sel_1] <= i_src2_tag_1;
        end
        if (i_alloc_vld_2) begin
            tag1_q[i_alloc_sel_2] <= i_src1_tag_2;
            tag2_q[i_alloc_sel_2] <= i_src2_tag_2;
        end
    end

    always @(posedge i_clk) begin
        if (!i_rst) begin
            if (i_alloc_vld_1) assert (!busy_q[i_alloc_sel_1]);
            if (i_alloc_vld_2) assert (!busy_q[i_alloc_sel_2]);
            if (i_alloc_vld_1 && i_alloc_vld_2)
                assert (i_alloc_sel_1 != i_alloc_sel_2);
        end
    end

endmodule
